// File: rtl/riscv_inst_decoder.sv
// Two-stage pipelined RV32 instruction decoder with valid/ready handshake on both sides.
// Optional saturating statistics counters are enabled with the RISCV_INST_DECODER_STATS_EN macro.
module riscv_inst_decoder #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_type,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
`ifdef RISCV_INST_DECODER_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_decoded,
    output logic [CNT_W-1:0] stat_illegal
`endif
);

    localparam logic [2:0] TYPE_R   = 3'd0;
    localparam logic [2:0] TYPE_I   = 3'd1;
    localparam logic [2:0] TYPE_S   = 3'd2;
    localparam logic [2:0] TYPE_B   = 3'd3;
    localparam logic [2:0] TYPE_U   = 3'd4;
    localparam logic [2:0] TYPE_J   = 3'd5;
    localparam logic [2:0] TYPE_C0  = 3'd6;
    localparam logic [2:0] TYPE_ILL = 3'd7;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_U     = 7'b0010111;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_C0    = 7'b0001011;

    localparam logic [6:0] F7_ZERO  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    generate
        if (XLEN < 32 || CNT_W < 1) begin : g_param_check
            $error("riscv_inst_decoder: XLEN must be >= 32 and CNT_W >= 1");
        end
    endgenerate

    logic            rdy_en_reg;
    logic            s1_valid_reg;
    logic [31:0]     s1_inst_reg;
    logic            s2_valid_reg;
    logic [31:0]     s2_inst_reg;
    logic [2:0]      s2_type_reg;
    logic [XLEN-1:0] s2_imm_reg;

    logic            s2_free;
    logic            s1_advance;
    logic            in_xfer;

    // Downstream slot is free when empty or being emptied this cycle.
    assign s2_free    = !s2_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_free;
    assign in_ready   = rdy_en_reg && !rst && !flush && (!s1_valid_reg || s1_advance);
    assign in_xfer    = in_valid && in_ready;

    // ---------------- Stage 1: capture and classify ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en_reg   <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_inst_reg  <= '0;
        end else begin
            rdy_en_reg <= 1'b1;
            if (flush) begin
                s1_valid_reg <= 1'b0;
            end else if (in_xfer) begin
                s1_valid_reg <= 1'b1;
                s1_inst_reg  <= in_inst;
            end else if (s1_advance) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    logic [6:0]      s1_opcode;
    logic [2:0]      s1_f3;
    logic [6:0]      s1_f7;
    logic [2:0]      dec_type;
    logic [31:0]     dec_imm32;
    logic            dec_bad;
    logic [XLEN-1:0] dec_imm;

    assign s1_opcode = s1_inst_reg[6:0];
    assign s1_f3     = s1_inst_reg[14:12];
    assign s1_f7     = s1_inst_reg[31:25];

    always_comb begin
        dec_type  = TYPE_ILL;
        dec_imm32 = '0;
        dec_bad   = 1'b0;
        case (s1_opcode)
            OP_R: begin
                dec_type = TYPE_R;
                dec_bad  = !((s1_f7 == F7_ZERO) ||
                             ((s1_f7 == F7_ALT) && ((s1_f3 == 3'b000) || (s1_f3 == 3'b101))));
            end
            OP_I: begin
                dec_type  = TYPE_I;
                dec_imm32 = {{20{s1_inst_reg[31]}}, s1_inst_reg[31:20]};
                dec_bad   = ((s1_f3 == 3'b001) && (s1_f7 != F7_ZERO)) ||
                            ((s1_f3 == 3'b101) && (s1_f7 != F7_ZERO) && (s1_f7 != F7_ALT));
            end
            OP_S: begin
                dec_type  = TYPE_S;
                dec_imm32 = {{20{s1_inst_reg[31]}}, s1_inst_reg[31:25], s1_inst_reg[11:7]};
                dec_bad   = (s1_f3 > 3'b010);
            end
            OP_B: begin
                dec_type  = TYPE_B;
                dec_imm32 = {{20{s1_inst_reg[31]}}, s1_inst_reg[7], s1_inst_reg[30:25],
                             s1_inst_reg[11:8], 1'b0};
                dec_bad   = (s1_f3 == 3'b010) || (s1_f3 == 3'b011);
            end
            OP_U: begin
                dec_type  = TYPE_U;
                dec_imm32 = {s1_inst_reg[31:12], 12'b0};
            end
            OP_J: begin
                dec_type  = TYPE_J;
                dec_imm32 = {{12{s1_inst_reg[31]}}, s1_inst_reg[19:12], s1_inst_reg[20],
                             s1_inst_reg[30:21], 1'b0};
            end
            OP_C0: begin
                dec_type = TYPE_C0;
                dec_bad  = (s1_f3 != 3'b000);
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
        if (dec_bad) begin
            dec_type  = TYPE_ILL;
            dec_imm32 = '0;
        end
    end

    // Sign-extend the 32-bit immediate up to XLEN (no extra bits when XLEN == 32).
    assign dec_imm[31:0] = dec_imm32;
    generate
        for (genvar gi = 32; gi < XLEN; gi++) begin : g_sext
            assign dec_imm[gi] = dec_imm32[31];
        end
    endgenerate

    // ---------------- Stage 2: decoded result holding register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_inst_reg  <= '0;
            s2_type_reg  <= '0;
            s2_imm_reg   <= '0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s1_advance) begin
            s2_valid_reg <= 1'b1;
            s2_inst_reg  <= s1_inst_reg;
            s2_type_reg  <= dec_type;
            s2_imm_reg   <= dec_imm;
        end else if (out_ready) begin
            s2_valid_reg <= 1'b0;
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_type    = s2_type_reg;
    assign out_opcode  = s2_inst_reg[6:0];
    assign out_rd      = s2_inst_reg[11:7];
    assign out_rs1     = s2_inst_reg[19:15];
    assign out_rs2     = s2_inst_reg[24:20];
    assign out_funct3  = s2_inst_reg[14:12];
    assign out_funct7  = s2_inst_reg[31:25];
    assign out_imm     = s2_imm_reg;
    assign out_illegal = (s2_type_reg == TYPE_ILL);

`ifdef RISCV_INST_DECODER_STATS_EN
    logic [CNT_W-1:0] stat_decoded_reg;
    logic [CNT_W-1:0] stat_illegal_reg;
    logic             out_xfer;

    // A flush in the same cycle as out_ready drops the entry, so it is not counted.
    assign out_xfer = s2_valid_reg && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_decoded_reg <= '0;
            stat_illegal_reg <= '0;
        end else if (out_xfer) begin
            if (stat_decoded_reg != '1) begin
                stat_decoded_reg <= stat_decoded_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (out_illegal && (stat_illegal_reg != '1)) begin
                stat_illegal_reg <= stat_illegal_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stat_decoded = stat_decoded_reg;
    assign stat_illegal = stat_illegal_reg;
`endif

endmodule

// File: tb/tb_riscv_inst_decoder.sv
// Scoreboard bench for riscv_inst_decoder: expectations queued on input transfer, compared on output transfer.
module tb_riscv_inst_decoder;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_type;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;
`ifdef RISCV_INST_DECODER_STATS_EN
    logic [CNT_W-1:0] stat_decoded;
    logic [CNT_W-1:0] stat_illegal;
`endif

    riscv_inst_decoder #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_type    (out_type),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
`ifdef RISCV_INST_DECODER_STATS_EN
        ,
        .stat_decoded(stat_decoded),
        .stat_illegal(stat_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   exp_dec = 0;
    int   exp_ill = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Independent reference decode: returns {type, imm}.
    function automatic logic [34:0] ref_dec(input logic [31:0] i);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  t;
        logic [31:0] imm;
        logic        bad;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        t = 3'd7; imm = 32'h0; bad = 1'b0;
        if (op == 7'h33) begin
            t = 3'd0;
            bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end else if (op == 7'h13) begin
            t = 3'd1;
            imm = {{20{i[31]}}, i[31:20]};
            bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        end else if (op == 7'h23) begin
            t = 3'd2;
            imm = {{20{i[31]}}, i[31:25], i[11:7]};
            bad = (f3 > 3'd2);
        end else if (op == 7'h63) begin
            t = 3'd3;
            imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            bad = (f3 == 3'd2 || f3 == 3'd3);
        end else if (op == 7'h17) begin
            t = 3'd4;
            imm = {i[31:12], 12'h000};
        end else if (op == 7'h6f) begin
            t = 3'd5;
            imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        end else if (op == 7'h0b) begin
            t = 3'd6;
            bad = (f3 != 3'd0);
        end else begin
            bad = 1'b1;
        end
        if (bad) begin
            t = 3'd7;
            imm = 32'h0;
        end
        return {t, imm};
    endfunction

    // Output monitor: pops the scoreboard on each output transfer and checks hold under backpressure.
    logic        hold_pend = 1'b0;
    logic [35:0] hold_fields;
    logic [31:0] hold_imm;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_dec = 0;
            exp_ill = 0;
            hold_pend = 1'b0;
        end else if (flush) begin
            sb.delete();
            hold_pend = 1'b0;
        end else begin
`ifdef RISCV_INST_DECODER_STATS_EN
            chk("stat_decoded", 64'(stat_decoded), 64'(exp_dec));
            chk("stat_illegal", 64'(stat_illegal), 64'(exp_ill));
`endif
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_fields", 64'({out_type, out_opcode, out_rd, out_rs1, out_rs2,
                                        out_funct3, out_funct7, out_illegal}), 64'(hold_fields));
                chk("hold_imm", 64'(out_imm), 64'(hold_imm));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("out  inst=%08h type=%0d imm=%08h", e.inst, out_type, out_imm);
                    chk("type",    64'(out_type),    64'(e.typ));
                    chk("imm",     64'(out_imm),     64'(e.imm));
                    chk("illegal", 64'(out_illegal), 64'(e.typ == 3'd7));
                    chk("opcode",  64'(out_opcode),  64'(e.inst[6:0]));
                    chk("rd",      64'(out_rd),      64'(e.inst[11:7]));
                    chk("rs1",     64'(out_rs1),     64'(e.inst[19:15]));
                    chk("rs2",     64'(out_rs2),     64'(e.inst[24:20]));
                    chk("funct3",  64'(out_funct3),  64'(e.inst[14:12]));
                    chk("funct7",  64'(out_funct7),  64'(e.inst[31:25]));
                    n_out++;
                    exp_dec++;
                    if (e.typ == 3'd7) exp_ill++;
                end
            end
            hold_pend   = out_valid && !out_ready;
            hold_fields = {out_type, out_opcode, out_rd, out_rs1, out_rs2,
                           out_funct3, out_funct7, out_illegal};
            hold_imm    = out_imm;
        end
    end

    task automatic send(input logic [31:0] inst, input logic [2:0] typ, input logic [31:0] imm);
        exp_t e;
        in_valid = 1'b1;
        in_inst  = inst;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready && !rst && !flush) begin
                e.inst = inst; e.typ = typ; e.imm = imm;
                sb.push_back(e);
                n_acc++;
                $display("in   inst=%08h exp_type=%0d exp_imm=%08h", inst, typ, imm);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_inst  = $urandom;
                return;
            end
        end
        chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] inst);
        logic [34:0] r;
        r = ref_dec(inst);
        send(inst, r[34:32], r[31:0]);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) return;
        end
        chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [8];
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h23; ops[3] = 7'h63;
        ops[4] = 7'h17; ops[5] = 7'h6f; ops[6] = 7'h0b; ops[7] = 7'($urandom);
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 7)];
        case ($urandom_range(0, 2))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    logic rand_done;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 32'h0;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_type",      64'(out_type),  64'd0);
        chk("rst_imm",       64'(out_imm),   64'd0);
        chk("rst_illegal",   64'(out_illegal), 64'd0);
        chk("rst_rd",        64'(out_rd),    64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // addi x1,x2,-1 with explicit latency check
        tick();
        out_ready = 1'b1;
        send(32'hFFF10093, 3'd1, 32'hFFFFFFFF);
        @(negedge clk);
        chk("latency_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_s2", 64'(out_valid), 64'd1);
        wait_drain();

        // back-to-back store, branch, jump
        tick();
        send(32'h00512423, 3'd2, 32'h00000008);
        send(32'hFE000EE3, 3'd3, 32'hFFFFFFFC);
        send(32'h008000EF, 3'd5, 32'h00000008);
        wait_drain();

        // illegal encodings
        tick();
        send(32'h00000000, 3'd7, 32'h0);
        send(32'h40001013, 3'd7, 32'h0);
        send(32'h0000300B, 3'd7, 32'h0);
        wait_drain();
`ifdef RISCV_INST_DECODER_STATS_EN
        chk("stat_illegal_3", 64'(stat_illegal), 64'd3);
`endif

        // backpressure: only two words fit while out_ready is low
        tick();
        out_ready = 1'b0;
        begin
            int base_acc;
            int base_out;
            base_acc = n_acc;
            base_out = n_out;
            fork
                begin
                    for (int k = 0; k < 4; k++) send_m(32'h00100093 + (32'(k) << 20));
                end
                begin
                    repeat (6) @(negedge clk);
                    chk("bp_accepted", 64'(n_acc - base_acc), 64'd2);
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                    tick();
                    out_ready = 1'b1;
                end
            join
            wait_drain();
            chk("bp_emerged", 64'(n_out - base_out), 64'd4);
        end

        // random stream with random backpressure
        tick();
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    send_m(rand_inst());
                    if ($urandom_range(0, 3) == 0) tick();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        tick();
        out_ready = 1'b1;
        wait_drain();

        // flush with both stages full; flush wins over out_ready
        tick();
        out_ready = 1'b0;
        send_m(32'h00A00113);
        send_m(32'h00B00193);
        begin
            int snap_dec;
            snap_dec = exp_dec;
            flush     = 1'b1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_inst   = 32'h00C00213;
            @(negedge clk);
            chk("flush_in_ready", 64'(in_ready), 64'd0);
            tick();
            flush    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            chk("flush_out_valid", 64'(out_valid), 64'd0);
            chk("flush_in_ready_after", 64'(in_ready), 64'd1);
`ifdef RISCV_INST_DECODER_STATS_EN
            chk("flush_stat", 64'(stat_decoded), 64'(snap_dec));
`else
            chk("flush_no_count", 64'(exp_dec), 64'(snap_dec));
`endif
        end
        tick();
        send(32'hFFF10093, 3'd1, 32'hFFFFFFFF);
        @(negedge clk);
        chk("post_flush_lat_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("post_flush_lat_s2", 64'(out_valid), 64'd1);
        wait_drain();

        // reset while output is valid
        tick();
        out_ready = 1'b0;
        send_m(32'h123450B7 ^ 32'h000000A0);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_type",      64'(out_type),  64'd0);
        chk("mid_rst_imm",       64'(out_imm),   64'd0);
        chk("mid_rst_rs1",       64'(out_rs1),   64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd0);
`ifdef RISCV_INST_DECODER_STATS_EN
        chk("mid_rst_stat_dec", 64'(stat_decoded), 64'd0);
        chk("mid_rst_stat_ill", 64'(stat_illegal), 64'd0);
`endif
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready0", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rst_release_in_ready1", 64'(in_ready), 64'd1);

        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) send_m(rand_inst());
        wait_drain();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule
